// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first.
// One full-subtractor cell plus a borrow flop; start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] work;
  logic [CW-1:0]    cnt;
  logic             bin;
  logic             d;
  logic             bout;
  logic [WIDTH-1:0] work_nxt;

  assign d        = sa[0] ^ sb[0] ^ bin;
  assign bout     = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bin);
  assign work_nxt = {d, work[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      sa     <= '0;
      sb     <= '0;
      work   <= '0;
      cnt    <= '0;
      bin    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            bin   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          sa   <= sa >> 1;
          sb   <= sb >> 1;
          work <= work_nxt;
          bin  <= bout;
          if (cnt == LAST) begin
            diff   <= work_nxt;
            borrow <= bout;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= S_FIN;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_FIN: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            bin   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
